// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control path: ALU codes, opcodes,
// funct codes, controller states and datapath select codes.
// Purely declarative; no timing or flow control lives here.
package mips_pkg;

    // ALU operation codes
    localparam logic [3:0] ALU_ADD   = 4'h0;
    localparam logic [3:0] ALU_SUB   = 4'h1;
    localparam logic [3:0] ALU_OR    = 4'h2;
    localparam logic [3:0] ALU_SLT   = 4'h3;
    localparam logic [3:0] ALU_SLL   = 4'h4;
    localparam logic [3:0] ALU_SRL   = 4'h5;
    localparam logic [3:0] ALU_SRA   = 4'h6;
    localparam logic [3:0] ALU_SLLV  = 4'h7;
    localparam logic [3:0] ALU_SRLV  = 4'h8;
    localparam logic [3:0] ALU_SRAV  = 4'h9;
    localparam logic [3:0] ALU_AND   = 4'hA;
    localparam logic [3:0] ALU_XOR   = 4'hB;
    localparam logic [3:0] ALU_NOR   = 4'hC;
    localparam logic [3:0] ALU_PASSA = 4'hD;
    localparam logic [3:0] ALU_SLTU  = 4'hE;

    // Opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type funct codes (IR[5:0])
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    // Controller states
    typedef enum logic [2:0] {
        ST_IF  = 3'd0,
        ST_ID  = 3'd1,
        ST_EX  = 3'd2,
        ST_MEM = 3'd3,
        ST_WB  = 3'd4
    } state_e;

    // ALU operand A select
    localparam logic [1:0] ASRC_PC   = 2'd0;
    localparam logic [1:0] ASRC_RS   = 2'd1;
    localparam logic [1:0] ASRC_ZERO = 2'd2;

    // ALU operand B select
    localparam logic [1:0] BSRC_RT   = 2'd0;
    localparam logic [1:0] BSRC_FOUR = 2'd1;
    localparam logic [1:0] BSRC_IMM  = 2'd2;
    localparam logic [1:0] BSRC_LUI  = 2'd3;

    // Register file destination select
    localparam logic [1:0] RDST_RT = 2'd0;
    localparam logic [1:0] RDST_RD = 2'd1;
    localparam logic [1:0] RDST_RA = 2'd2;

    // Register write-data select
    localparam logic [1:0] M2R_ALUOUT = 2'd0;
    localparam logic [1:0] M2R_MDR    = 2'd1;
    localparam logic [1:0] M2R_PC     = 2'd2;

    // Next-PC select
    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;
    localparam logic [1:0] PCSRC_RS     = 2'd3;

    // Loads and stores are the only instructions that visit the MEM state.
    function automatic logic is_mem_op(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/mips_mc_ctrl_alu_dec.sv
// Instruction decoder: opcode/funct -> EX-stage ALU code, operand-B select, extension mode, legality.
// Latency: purely combinational, zero cycles.
// Backpressure: none; outputs follow the IR fields directly.
module alu_dec
    import mips_pkg::*;
(
    input  logic [5:0] opcode_i,
    input  logic [5:0] funct_i,
    output logic [3:0] aluop_o,
    output logic [1:0] alusrc_b_o,
    output logic       ext_sign_o,
    output logic       legal_o
);

    // Map each recognised instruction to its execute-stage ALU setup.
    always_comb begin
        aluop_o    = ALU_ADD;
        alusrc_b_o = BSRC_RT;
        ext_sign_o = 1'b0;
        legal_o    = 1'b0;
        unique case (opcode_i)
            OP_RTYPE: begin
                legal_o = 1'b1;
                unique case (funct_i)
                    FN_ADD, FN_ADDU: aluop_o = ALU_ADD;
                    FN_SUB, FN_SUBU: aluop_o = ALU_SUB;
                    FN_AND:          aluop_o = ALU_AND;
                    FN_OR:           aluop_o = ALU_OR;
                    FN_XOR:          aluop_o = ALU_XOR;
                    FN_NOR:          aluop_o = ALU_NOR;
                    FN_SLT:          aluop_o = ALU_SLT;
                    FN_SLTU:         aluop_o = ALU_SLTU;
                    FN_SLL:          aluop_o = ALU_SLL;
                    FN_SRL:          aluop_o = ALU_SRL;
                    FN_SRA:          aluop_o = ALU_SRA;
                    FN_SLLV:         aluop_o = ALU_SLLV;
                    FN_SRLV:         aluop_o = ALU_SRLV;
                    FN_SRAV:         aluop_o = ALU_SRAV;
                    FN_JR:           aluop_o = ALU_ADD;
                    default:         legal_o = 1'b0;
                endcase
            end
            OP_J, OP_JAL: begin
                legal_o = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                aluop_o = ALU_SUB;
                legal_o = 1'b1;
            end
            OP_ADDI, OP_ADDIU, OP_LW, OP_SW: begin
                aluop_o    = ALU_ADD;
                alusrc_b_o = BSRC_IMM;
                ext_sign_o = 1'b1;
                legal_o    = 1'b1;
            end
            OP_SLTI: begin
                aluop_o    = ALU_SLT;
                alusrc_b_o = BSRC_IMM;
                ext_sign_o = 1'b1;
                legal_o    = 1'b1;
            end
            OP_SLTIU: begin
                aluop_o    = ALU_SLTU;
                alusrc_b_o = BSRC_IMM;
                ext_sign_o = 1'b1;
                legal_o    = 1'b1;
            end
            OP_ANDI: begin
                aluop_o    = ALU_AND;
                alusrc_b_o = BSRC_IMM;
                legal_o    = 1'b1;
            end
            OP_ORI: begin
                aluop_o    = ALU_OR;
                alusrc_b_o = BSRC_IMM;
                legal_o    = 1'b1;
            end
            OP_XORI: begin
                aluop_o    = ALU_XOR;
                alusrc_b_o = BSRC_IMM;
                legal_o    = 1'b1;
            end
            OP_LUI: begin
                aluop_o    = ALU_OR;
                alusrc_b_o = BSRC_LUI;
                legal_o    = 1'b1;
            end
            default: legal_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multicycle MIPS controller: sequences IF/ID/EX/MEM/WB and drives all datapath selects and enables.
// Latency: j/jal/jr 2, branch 3, ALU op 4, sw 4, lw 5 cycles at zero wait; outputs are combinational.
// Backpressure: IF and MEM hold their request until mem_ready; reset low forces every output to 0.
module mips_mc_ctrl
    import mips_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic [3:0] aluop,
    output logic [1:0] alusrc_a,
    output logic [1:0] alusrc_b,
    output logic       ext_sign,
    output logic       mem_re,
    output logic       mem_we,
    output logic       iord,
    output logic       ir_we,
    output logic       pc_we,
    output logic       reg_we,
    output logic [1:0] regdst,
    output logic [1:0] memtoreg,
    output logic [1:0] pc_src,
    output logic       illegal
);

    state_e     state_q, state_d;

    logic [3:0] dec_aluop;
    logic [1:0] dec_alusrc_b;
    logic       dec_ext_sign;
    logic       dec_legal;

    logic       is_rtype;
    logic       is_jr;

    assign is_rtype = (opcode == OP_RTYPE);
    assign is_jr    = is_rtype && (funct == FN_JR);

    alu_dec u_alu_dec (
        .opcode_i   (opcode),
        .funct_i    (funct),
        .aluop_o    (dec_aluop),
        .alusrc_b_o (dec_alusrc_b),
        .ext_sign_o (dec_ext_sign),
        .legal_o    (dec_legal)
    );

    // State register; reset parks the controller in IF.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IF;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and output decode. While reset is held every output is
    // forced low so an aborted instruction cannot leak a write enable.
    always_comb begin
        state_d  = state_q;
        aluop    = ALU_ADD;
        alusrc_a = ASRC_PC;
        alusrc_b = BSRC_RT;
        ext_sign = 1'b0;
        mem_re   = 1'b0;
        mem_we   = 1'b0;
        iord     = 1'b0;
        ir_we    = 1'b0;
        pc_we    = 1'b0;
        reg_we   = 1'b0;
        regdst   = RDST_RT;
        memtoreg = M2R_ALUOUT;
        pc_src   = PCSRC_ALU;
        illegal  = 1'b0;

        unique case (state_q)
            ST_IF: begin
                // Fetch at PC and compute PC+4 in the same cycle.
                mem_re   = 1'b1;
                alusrc_b = BSRC_FOUR;
                if (mem_ready) begin
                    ir_we   = 1'b1;
                    pc_we   = 1'b1;
                    state_d = ST_ID;
                end
            end
            ST_ID: begin
                // Speculatively form the branch target into ALU-out.
                alusrc_b = BSRC_IMM;
                ext_sign = 1'b1;
                if (opcode == OP_J || opcode == OP_JAL) begin
                    pc_we   = 1'b1;
                    pc_src  = PCSRC_JUMP;
                    if (opcode == OP_JAL) begin
                        reg_we   = 1'b1;
                        regdst   = RDST_RA;
                        memtoreg = M2R_PC;
                    end
                    state_d = ST_IF;
                end else if (is_jr) begin
                    pc_we   = 1'b1;
                    pc_src  = PCSRC_RS;
                    state_d = ST_IF;
                end else if (!dec_legal) begin
                    illegal = 1'b1;
                    state_d = ST_IF;
                end else begin
                    state_d = ST_EX;
                end
            end
            ST_EX: begin
                aluop    = dec_aluop;
                alusrc_a = (opcode == OP_LUI) ? ASRC_ZERO : ASRC_RS;
                alusrc_b = dec_alusrc_b;
                ext_sign = dec_ext_sign;
                if (opcode == OP_BEQ || opcode == OP_BNE) begin
                    pc_we   = (opcode == OP_BEQ) ? zero : !zero;
                    pc_src  = PCSRC_ALUOUT;
                    state_d = ST_IF;
                end else if (is_mem_op(opcode)) begin
                    state_d = ST_MEM;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM: begin
                iord   = 1'b1;
                mem_re = (opcode == OP_LW);
                mem_we = (opcode == OP_SW);
                if (mem_ready) begin
                    state_d = (opcode == OP_LW) ? ST_WB : ST_IF;
                end
            end
            ST_WB: begin
                reg_we   = 1'b1;
                regdst   = is_rtype ? RDST_RD : RDST_RT;
                memtoreg = (opcode == OP_LW) ? M2R_MDR : M2R_ALUOUT;
                state_d  = ST_IF;
            end
            default: begin
                state_d = ST_IF;
            end
        endcase

        if (!rst_n) begin
            state_d  = ST_IF;
            aluop    = '0;
            alusrc_a = '0;
            alusrc_b = '0;
            ext_sign = 1'b0;
            mem_re   = 1'b0;
            mem_we   = 1'b0;
            iord     = 1'b0;
            ir_we    = 1'b0;
            pc_we    = 1'b0;
            reg_we   = 1'b0;
            regdst   = '0;
            memtoreg = '0;
            pc_src   = '0;
            illegal  = 1'b0;
        end
    end

endmodule
